// File: rtl/fpm_share_ctrl_pkg.sv
// fpm_share_pkg: shared constants for the FPM sharing controller.
//   N_REQ_DEF / W_DEF / CNT_W_DEF : default requester count, data width, counter width
//   TAG_W                         : requester tag width for the default requester count
//   FPM_LAT                       : accept-to-response latency in cycles (operand reg + result reg)
//   next_idx()                    : round-robin successor of an index, wrapping at n
package fpm_share_pkg;

   localparam int N_REQ_DEF = 4;
   localparam int W_DEF     = 32;
   localparam int CNT_W_DEF = 16;
   localparam int TAG_W     = $clog2(N_REQ_DEF);
   localparam int FPM_LAT   = 2;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fpm_share_ctrl_if.sv
// fpm_share_ctrl_if: request and response buses of the FPM sharing controller.
//   req_valid/req_ready : per-requester handshake, one bit per requester
//   req_a/req_b         : operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : shared response handshake
//   rsp_data/rsp_tag    : product and index of the issuing requester
// Handshake rule for both buses: a beat transfers on the rising edge where
// valid and ready are both high. The producer holds valid and its payload
// until that edge. req_ready depends combinationally on req_valid, so
// requesters must not derive req_valid from req_ready.
// modport master: requesters + response consumer; modport slave: the controller.
interface fpm_share_ctrl_if #(
   parameter int N_REQ = 4,
   parameter int W     = 32,
   parameter int TAG_W = 2
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [W-1:0]       rsp_data;
   logic [TAG_W-1:0]   rsp_tag;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_tag
   );
endinterface

// File: rtl/fpm_share_ctrl_fpm.sv
// fpm_core: combinational IEEE-754 single precision multiplier.
//   a_i, b_i : operands
//   p_o      : product, round to nearest even
// Subnormal inputs and subnormal results are flushed to signed zero. Any NaN
// input or inf*0 gives the quiet NaN 0x7FC00000.
module fpm_core (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] p_o
);
   logic        sign;
   logic [7:0]  ea, eb;
   logic [22:0] ma, mb;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [47:0] prod;
   logic        norm, guard, sticky;
   logic [22:0] frac;
   logic [23:0] rnd;
   logic [9:0]  exp_s;

   always_comb begin
      sign   = a_i[31] ^ b_i[31];
      ea     = a_i[30:23];
      eb     = b_i[30:23];
      ma     = a_i[22:0];
      mb     = b_i[22:0];
      a_nan  = (ea == 8'hFF) && (ma != 23'd0);
      b_nan  = (eb == 8'hFF) && (mb != 23'd0);
      a_inf  = (ea == 8'hFF) && (ma == 23'd0);
      b_inf  = (eb == 8'hFF) && (mb == 23'd0);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);

      // Product of two 1.xxx significands lies in [1,4): bit 47 says which.
      prod = 48'({1'b1, ma}) * 48'({1'b1, mb});
      norm = prod[47];
      if (norm) begin
         frac   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         frac   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      rnd = {1'b0, frac} + 24'(guard & (sticky | frac[0]));
      // A rounding carry leaves rnd[22:0] all zero, so only the exponent moves.
      exp_s = {2'b00, ea} + {2'b00, eb} + {9'd0, norm} + {9'd0, rnd[23]} - 10'd127;

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         p_o = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         p_o = {sign, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         p_o = {sign, 31'd0};
      else if (exp_s[9] || (exp_s == 10'd0))
         p_o = {sign, 31'd0};
      else if (exp_s >= 10'd255)
         p_o = {sign, 8'hFF, 23'd0};
      else
         p_o = {sign, exp_s[7:0], rnd[22:0]};
   end
endmodule

// File: rtl/fpm_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i   : request vector
//   ptr_i   : highest-priority index; search runs upward from it with wrap
//   en_i    : when low no grant is given
//   grant_o : one-hot-or-zero grant
//   idx_o   : encoded index of the grant (0 when none)
module rr_arbiter
   import fpm_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int TW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [TW-1:0]    ptr_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [TW-1:0]    idx_o
);
   logic found;
   int   j;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (en_i && !found && req_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = TW'(j);
         end
      end
   end
endmodule

// File: rtl/fpm_share_ctrl.sv
// fpm_share_ctrl: shares one combinational FP multiplier among N_REQ requesters.
//   clk      : clock, all state on the rising edge
//   reset    : asynchronous active-low reset, discards in-flight ops
//   bus      : request/response buses (slave side)
//   busy     : an op is in stage 1 or stage 2
//   op_count : completed response handshakes, wrapping
// Pipeline: round-robin grant -> operand regs (v1) -> fpm_core -> result reg (v2).
// A response stall freezes both stages, even when stage 1 holds a bubble.
module fpm_share_ctrl
   import fpm_share_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   fpm_share_ctrl_if.slave  bus,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic             v1_q, v1_d, v2_q, v2_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
   logic [TW-1:0]    tag1_q, tag1_d, tag2_q, tag2_d;
   logic [TW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             advance, xfer;
   logic [N_REQ-1:0] grant;
   logic [TW-1:0]    gidx;
   logic [W-1:0]     sel_a, sel_b, fpm_p;

   assign advance = !v2_q || bus.rsp_ready;

   // Gated with reset so no grant is offered while the block is held in reset.
   rr_arbiter #(.N_REQ(N_REQ), .TW(TW)) u_arb (
      .req_i   (bus.req_valid),
      .ptr_i   (ptr_q),
      .en_i    (advance & reset),
      .grant_o (grant),
      .idx_o   (gidx)
   );

   assign xfer  = |grant;
   assign sel_a = bus.req_a[int'(gidx)*W +: W];
   assign sel_b = bus.req_b[int'(gidx)*W +: W];

   fpm_core u_fpm (
      .a_i (a_q),
      .b_i (b_q),
      .p_o (fpm_p)
   );

   always_comb begin
      v1_d   = v1_q;
      v2_d   = v2_q;
      a_d    = a_q;
      b_d    = b_q;
      res_d  = res_q;
      tag1_d = tag1_q;
      tag2_d = tag2_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q + CNT_W'(v2_q & bus.rsp_ready);
      if (xfer)
         ptr_d = TW'(next_idx(int'(gidx), N_REQ));
      if (advance) begin
         v1_d   = xfer;
         tag1_d = gidx;
         if (xfer) begin
            a_d = sel_a;
            b_d = sel_b;
         end
         v2_d   = v1_q;
         res_d  = fpm_p;
         tag2_d = tag1_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         tag1_q <= '0;
         tag2_q <= '0;
         ptr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         a_q    <= a_d;
         b_q    <= b_d;
         res_q  <= res_d;
         tag1_q <= tag1_d;
         tag2_q <= tag2_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = v2_q;
   assign bus.rsp_data  = res_q;
   assign bus.rsp_tag   = tag2_q;
   assign busy          = v1_q | v2_q;
   assign op_count      = cnt_q;
endmodule

// File: tb/tb_fpm_share_ctrl.sv
// tb_fpm_share_ctrl: directed bench for fpm_share_ctrl with a response scoreboard.
module tb_fpm_share_ctrl;
   import fpm_share_pkg::*;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int TW = 2;

   // ---------------- clock / reset ----------------
   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        busy;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   fpm_share_ctrl_if #(.N_REQ(N), .W(W), .TAG_W(TW)) bus ();

   fpm_share_ctrl #(.N_REQ(N), .W(W), .CNT_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   // ---------------- vectors (hand-computed products) ----------------
   logic [31:0] ta [6];
   logic [31:0] tbv[6];
   logic [31:0] tp [6];
   logic [31:0] cur_p[N];

   initial begin
      ta[0] = 32'h3FC0_0000; tbv[0] = 32'h4000_0000; tp[0] = 32'h4040_0000; // 1.5*2 = 3
      ta[1] = 32'h4000_0000; tbv[1] = 32'h4040_0000; tp[1] = 32'h40C0_0000; // 2*3 = 6
      ta[2] = 32'hBF80_0000; tbv[2] = 32'h4080_0000; tp[2] = 32'hC080_0000; // -1*4 = -4
      ta[3] = 32'h3F00_0000; tbv[3] = 32'h3F00_0000; tp[3] = 32'h3E80_0000; // 0.5*0.5 = 0.25
      ta[4] = 32'h40E0_0000; tbv[4] = 32'h3F00_0000; tp[4] = 32'h4060_0000; // 7*0.5 = 3.5
      ta[5] = 32'h3F80_0000; tbv[5] = 32'h3FA0_0000; tp[5] = 32'h3FA0_0000; // 1*1.25 = 1.25
   end

   // ---------------- scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [33:0] exp_q[$];
   logic [15:0] exp_cnt = 16'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Monitor: a response handshakes on the edge after this negedge.
   always @(negedge clk) begin
      if (reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=%h/%h required=none", bus.rsp_tag, bus.rsp_data);
         end else begin
            check("rsp_tag_data", {30'd0, bus.rsp_tag, bus.rsp_data}, {30'd0, exp_q.pop_front()});
         end
         exp_cnt = exp_cnt + 16'd1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input int k);
      bus.req_a[i*W +: W] = ta[k];
      bus.req_b[i*W +: W] = tbv[k];
      cur_p[i]            = tp[k];
      bus.req_valid[i]    = 1'b1;
   endtask

   // One cycle: optionally check the grant, record any transfer as expected.
   task automatic step(input logic [3:0] exp_gr, input bit chk_gr);
      @(negedge clk);
      if (chk_gr) check("grant", 64'(bus.req_ready), 64'(exp_gr));
      for (int i = 0; i < N; i++)
         if (bus.req_valid[i] && bus.req_ready[i])
            exp_q.push_back({2'(i), cur_p[i]});
      @(posedge clk);
      #1;
   endtask

   // Bounded drain: with rsp_ready=1 the pipeline empties within 3 cycles.
   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) cur_p[i] = '0;

      // Reset state; requests present during reset must not be granted.
      repeat (2) @(posedge clk);
      #1;
      bus.req_valid = 4'hF;
      #1;
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
      check("rst_rsp_tag",   64'(bus.rsp_tag),   64'd0);
      check("rst_busy",      64'(busy),          64'd0);
      check("rst_op_count",  64'(op_count),      64'd0);
      bus.req_valid = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Round robin: all four valid for 8 cycles.
      for (int k = 0; k < 4; k++) set_req(k, k);
      for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)), 1'b1);
      bus.req_valid = '0;
      drain();
      check("rr_op_count", 64'(op_count), 64'd8);

      // Single op from requester 2, latency and one-cycle response.
      set_req(2, 0);
      step(4'b0100, 1'b1);
      bus.req_valid = '0;
      @(negedge clk);
      check("lat_c1_valid", 64'(bus.rsp_valid), 64'd0);
      check("lat_c1_busy",  64'(busy),          64'd1);
      @(negedge clk);
      check("lat_c2_valid", 64'(bus.rsp_valid), 64'd1);
      check("lat_c2_data",  64'(bus.rsp_data),  64'h4040_0000);
      check("lat_c2_tag",   64'(bus.rsp_tag),   64'd2);
      @(negedge clk);
      check("lat_c3_valid", 64'(bus.rsp_valid), 64'd0);
      check("lat_c3_busy",  64'(busy),          64'd0);
      check("single_op_count", 64'(op_count),   64'd9);
      @(posedge clk);
      #1;

      // Pointer fairness: grant 3, then {1,3} -> 1 (wrap), then {1,3} -> 3.
      set_req(3, 1);
      step(4'b1000, 1'b1);
      bus.req_valid = '0;
      set_req(1, 2);
      set_req(3, 3);
      step(4'b0010, 1'b1);
      step(4'b1000, 1'b1);
      bus.req_valid = '0;
      drain();

      // Backpressure: stream from requester 0, then 5 stalled cycles.
      for (int k = 0; k < 3; k++) begin
         set_req(0, k);
         step(4'b0001, 1'b1);
      end
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_req(0, 3 + (k % 3));
         @(negedge clk);
         check("bp_req_ready", 64'(bus.req_ready), 64'd0);
         check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
         check("bp_rsp_hold",  {30'd0, bus.rsp_tag, bus.rsp_data}, {30'd0, exp_q[0]});
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      step(4'b0001, 1'b1);
      set_req(0, 5);
      step(4'b0001, 1'b1);
      bus.req_valid = '0;
      drain();
      check("bp_op_count", 64'(op_count), 64'(exp_cnt));
      check("bp_op_count_abs", 64'(op_count), 64'd17);

      // Reset with two ops in flight (grants 1 then 2 leave the pointer at 3).
      set_req(1, 4);
      step(4'b0010, 1'b1);
      bus.req_valid = '0;
      set_req(2, 5);
      step(4'b0100, 1'b1);
      bus.req_valid = '0;
      reset = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("mid_rst_busy",      64'(busy),          64'd0);
      check("mid_rst_op_count",  64'(op_count),      64'd0);
      exp_q.delete();
      exp_cnt = 16'd0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      // Pointer was cleared: with all valid the grant goes to 0.
      for (int k = 0; k < 4; k++) set_req(k, k);
      step(4'b0001, 1'b1);
      bus.req_valid = '0;
      drain();
      check("post_rst_op_count", 64'(op_count), 64'd1);

      // Counter wrap: bring the total to exactly 65536 handshakes.
      n = 65536 - int'(exp_cnt);
      set_req(0, 5);
      for (int k = 0; k < n; k++) step(4'b0001, 1'b0);
      bus.req_valid = '0;
      drain();
      check("wrap_op_count", 64'(op_count), 64'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
